// File: rtl/lw_sha_axi_pkg.sv
// Shared types and AXI constants for the lightweight AXI4 burst master.
package lw_sha_axi_pkg;

    // Controller states: command intake, write fill/address/data/response,
    // read address/data, and the one-cycle completion report.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    // Completion status reported alongside the done pulse.
    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,  // burst completed cleanly
        STATUS_RD_ERR  = 2'b01,  // read completed, some beat had rresp != OKAY
        STATUS_WR_FAIL = 2'b10,  // write failed (DECERR or SLVERR after all replays)
        STATUS_PROTO   = 2'b11   // read rlast framing did not match the burst length
    } status_t;

    // AXI response and burst encodings.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // AxSIZE encoding for a full-width beat of data_w bits.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/lw_sha_beat_buf.sv
// Beat buffer: holds one write burst so it can be replayed after SLVERR.
// One synchronous write port, one combinational read port.
module lw_sha_beat_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Capture one incoming beat per write enable.
    // NOTE: storage is deliberately not reset; every entry is written before it is read.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lw_sha_axi4_burst_master.sv
// Lightweight AXI4 burst master: buffers a write burst from a beat stream
// and replays it on SLVERR, or streams a read burst straight through while
// checking response codes and rlast framing.
module lw_sha_axi4_burst_master
    import lw_sha_axi_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int MAX_RETRY = 3,
    parameter int ID_W      = 4,
    localparam int LEN_W    = $clog2(MAX_BEATS),
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1)
) (
    input  logic               aclk,
    input  logic               aresetn,
    // command
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    // write-beat stream in
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    // read-beat stream out
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               rd_last,
    // completion
    output logic               done,
    output logic [1:0]         done_status,
    output logic [RETRY_W-1:0] done_retries,
    // AXI write address
    output logic [ADDR_W-1:0]  awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    output logic [ID_W-1:0]    awid,
    input  logic               awready,
    // AXI write data
    output logic [DATA_W-1:0]  wdata,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    // AXI write response
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready,
    // AXI read address
    output logic [ADDR_W-1:0]  araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    // AXI read data
    input  logic [DATA_W-1:0]  rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready
);

    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [2:0]         BEAT_SIZE   = axi_size(DATA_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic [RETRY_W-1:0]  retry_q;
    status_t             status_q;

    logic cmd_fire, fill_fire, w_fire, b_fire, r_fire, last_beat;
    logic resp_ok, can_retry;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign fill_fire = wr_valid & wr_ready;
    assign w_fire    = wvalid & wready;
    assign b_fire    = bvalid & bready;
    assign r_fire    = rvalid & rready;
    assign last_beat = (beat_q == len_q);
    assign resp_ok   = (bresp == RESP_OKAY) || (bresp == RESP_EXOKAY);
    assign can_retry = (bresp == RESP_SLVERR) && (retry_q < RETRY_LIMIT);

    // Address-channel encodings are fixed by the latched command.
    assign awaddr  = addr_q;
    assign awlen   = 8'(len_q);
    assign awsize  = BEAT_SIZE;
    assign awburst = BURST_INCR;
    assign awid    = '0;
    assign araddr  = addr_q;
    assign arlen   = 8'(len_q);
    assign arsize  = BEAT_SIZE;
    assign arburst = BURST_INCR;

    assign rd_data      = rdata;
    assign done_status  = status_q;
    assign done_retries = retry_q;

    // Buffered write beats; replays read the same entries again.
    lw_sha_beat_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_BEATS),
        .IDX_W  (LEN_W)
    ) u_beat_buf (
        .aclk  (aclk),
        .we    (fill_fire),
        .waddr (beat_q),
        .wdata (wr_data),
        .raddr (beat_q),
        .rdata (wdata)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; direction is carried by the FILL vs AR path.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_fire)               state_d = cmd_write ? ST_FILL : ST_AR;
            ST_FILL: if (fill_fire && last_beat) state_d = ST_AW;
            ST_AW:   if (awvalid && awready)     state_d = ST_W;
            ST_W:    if (w_fire && last_beat)    state_d = ST_B;
            ST_B: begin
                if (b_fire) begin
                    if (resp_ok)        state_d = ST_DONE;
                    else if (can_retry) state_d = ST_AW;
                    else                state_d = ST_DONE;
                end
            end
            ST_AR:   if (arvalid && arready)     state_d = ST_R;
            ST_R:    if (r_fire && last_beat)    state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_FILL: wr_ready  = 1'b1;
            ST_AW:   awvalid   = 1'b1;
            ST_W: begin
                wvalid = 1'b1;
                wlast  = last_beat;
            end
            ST_B:    bready    = 1'b1;
            ST_AR:   arvalid   = 1'b1;
            ST_R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = last_beat;
            end
            ST_DONE: done      = 1'b1;
            default: ;
        endcase
    end

    // Command latch, beat index, replay count and completion status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            retry_q  <= '0;
            status_q <= STATUS_OK;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        beat_q   <= '0;
                        retry_q  <= '0;
                        status_q <= STATUS_OK;
                    end
                end
                ST_FILL: begin
                    if (fill_fire) beat_q <= last_beat ? '0 : beat_q + 1'b1;
                end
                ST_W: begin
                    if (w_fire) beat_q <= last_beat ? '0 : beat_q + 1'b1;
                end
                ST_B: begin
                    if (b_fire) begin
                        if (resp_ok)        status_q <= STATUS_OK;
                        else if (can_retry) retry_q  <= retry_q + 1'b1;
                        else                status_q <= STATUS_WR_FAIL;
                    end
                end
                ST_R: begin
                    if (r_fire) begin
                        beat_q <= last_beat ? '0 : beat_q + 1'b1;
                        // Framing errors outrank response errors and stay sticky.
                        if (rlast != last_beat) begin
                            status_q <= STATUS_PROTO;
                        end else if (rresp != RESP_OKAY && status_q != STATUS_PROTO) begin
                            status_q <= STATUS_RD_ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lw_sha_axi4_burst_master.sv
// Self-checking bench for lw_sha_axi4_burst_master: directed vector table,
// randomized commands against a transaction-level model, and a mid-burst reset.
module tb_lw_sha_axi4_burst_master;
    import lw_sha_axi_pkg::*;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;
    localparam int MAX_RETRY = 3;
    localparam int ID_W      = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_ready, rd_last;
    logic              done;
    logic [1:0]        done_status;
    logic [1:0]        done_retries;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst;
    logic              awvalid, awready, arvalid, arready;
    logic [ID_W-1:0]   awid;
    logic [DATA_W-1:0] wdata, rdata;
    logic              wlast, wvalid, wready;
    logic [1:0]        bresp, rresp;
    logic              bvalid, bready;
    logic              rlast, rvalid, rready;

    always #5 aclk = ~aclk;

    lw_sha_axi4_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS),
        .MAX_RETRY(MAX_RETRY), .ID_W(ID_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .done_status(done_status), .done_retries(done_retries),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awid(awid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // One command plus the outcome expected for it.
    typedef struct {
        logic        wr;
        logic [11:0] addr;
        int          len;
        logic [31:0] base;    // beat i data = base ^ (i * golden constant), beat 0 = base
        logic [15:0] script;  // k-th B response in bits [2k+1:2k]
        logic [15:0] lmask;   // read beat i carries rlast when bit i set
        logic [15:0] emask;   // read beat i carries a non-OKAY rresp when bit i set
        logic        rnd;     // random readies / valids, rd_ready toggling
        logic [1:0]  exp_st;
        int          exp_rt;
        int          exp_att; // AW (or AR) handshakes
        int          exp_lat; // cycles from command accept to done, <0 = unchecked
    } vec_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] tb_data [16];
    vec_t        vecs [8];

    task automatic check(input string tag, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic set_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; arready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    endtask

    // Write outcome from the slave's response script: OKAY/EXOKAY finishes,
    // SLVERR replays while replays remain, anything else fails.
    function automatic void model_write(input logic [15:0] script, output logic [1:0] st,
                                        output int rt, output int att);
        logic [1:0] r;
        st = 2'b00; rt = 0; att = 0;
        for (int k = 0; k < 8; k++) begin
            r = script[2*k +: 2];
            att++;
            if (r == RESP_OKAY || r == RESP_EXOKAY) return;
            if (r == RESP_SLVERR && rt < MAX_RETRY) rt++;
            else begin
                st = 2'b10;
                return;
            end
        end
    endfunction

    // Read outcome: any misplaced or missing rlast -> 11, else any error beat -> 01.
    function automatic logic [1:0] model_read(input int len, input logic [15:0] lmask,
                                              input logic [15:0] emask);
        bit proto = 0;
        bit err = 0;
        for (int i = 0; i <= len; i++) begin
            if (lmask[i] != (i == len)) proto = 1;
            if (emask[i]) err = 1;
        end
        return proto ? 2'b11 : (err ? 2'b01 : 2'b00);
    endfunction

    // Drives one command with a responsive AXI slave and checks the outcome.
    // abort_beat >= 0 pulls reset while that W beat is on the bus.
    task automatic run_cmd(input vec_t v, input int abort_beat, input string tag);
        int   cyc, lat, aw_n, w_n, w_bad, b_i, r_i, rd_n, rd_bad, fill_i, idx, dn;
        logic accepted, finished, aborted, pend_b, r_act;
        logic [1:0] got_st, got_rt;
        cyc = 0; lat = 0; aw_n = 0; w_n = 0; w_bad = 0; b_i = 0; r_i = 0;
        rd_n = 0; rd_bad = 0; fill_i = 0; dn = 0;
        accepted = 0; finished = 0; aborted = 0; pend_b = 0; r_act = 0;
        got_st = '0; got_rt = '0;
        for (int i = 0; i < 16; i++)
            tb_data[i] = (i == 0) ? v.base : v.base ^ (32'(i) * 32'h9E37_79B9);
        @(negedge aclk);
        while (!finished && cyc < 2000) begin
            cmd_valid = !accepted;
            cmd_write = v.wr; cmd_addr = v.addr; cmd_len = 4'(v.len);
            wr_valid  = accepted && v.wr && (fill_i <= v.len) && (!v.rnd || $urandom_range(0, 3) != 0);
            wr_data   = (fill_i < 16) ? tb_data[fill_i] : '0;
            awready   = !v.rnd || ($urandom_range(0, 1) == 1);
            wready    = !v.rnd || ($urandom_range(0, 3) != 0);
            arready   = !v.rnd || ($urandom_range(0, 1) == 1);
            bvalid    = pend_b && (!v.rnd || $urandom_range(0, 2) != 0);
            bresp     = (b_i < 8) ? v.script[2*b_i +: 2] : RESP_OKAY;
            rvalid    = r_act && (r_i <= v.len) && (!v.rnd || $urandom_range(0, 3) != 0);
            rdata     = (r_i < 16) ? tb_data[r_i] : '0;
            rresp     = (r_i < 16 && v.emask[r_i]) ? ((r_i % 2 == 1) ? RESP_DECERR : RESP_SLVERR) : RESP_OKAY;
            rlast     = (r_i < 16) ? v.lmask[r_i] : 1'b0;
            rd_ready  = !v.rnd || (cyc % 2 == 0);
            #1;
            if (abort_beat >= 0 && wvalid && w_n == abort_beat) begin
                #2 aresetn = 1'b0;
                #1;
                check(tag, "wvalid_in_reset", wvalid, 1'b0);
                check(tag, "wlast_in_reset", wlast, 1'b0);
                check(tag, "done_in_reset", done, 1'b0);
                aborted = 1;
                break;
            end
            if (cmd_valid && cmd_ready && !accepted) begin
                accepted = 1;
                lat = 0;
            end
            if (wr_valid && wr_ready) fill_i++;
            if (awvalid && awready) begin
                aw_n++;
                check(tag, "awaddr", awaddr, v.addr);
                check(tag, "awlen", awlen, v.len);
                check(tag, "awsize", awsize, 3'd2);
                check(tag, "awburst", awburst, 2'b01);
                check(tag, "awid", awid, 4'd0);
            end
            if (wvalid && wready) begin
                idx = w_n % (v.len + 1);
                if (wdata !== tb_data[idx] || wlast !== (idx == v.len)) w_bad++;
                if (idx == v.len) pend_b = 1;
                w_n++;
            end
            if (bvalid && bready) begin
                b_i++;
                pend_b = 0;
            end
            if (arvalid && arready) begin
                aw_n++;
                check(tag, "araddr", araddr, v.addr);
                check(tag, "arlen", arlen, v.len);
                check(tag, "arsize_burst", {arsize, arburst}, {3'd2, 2'b01});
                r_act = 1;
            end
            if (rd_valid && rd_ready) begin
                if (rd_n > v.len || rd_data !== tb_data[rd_n] || rd_last !== (rd_n == v.len)) rd_bad++;
                rd_n++;
            end
            if (rvalid && rready) r_i++;
            if (done) begin
                got_st = done_status;
                got_rt = done_retries;
                check(tag, "cmd_ready_in_done", cmd_ready, 1'b0);
                if (v.exp_lat >= 0) check(tag, "latency", lat, v.exp_lat);
                finished = 1;
            end
            @(negedge aclk);
            cyc++;
            if (accepted) lat++;
        end
        set_idle();
        if (aborted) begin
            @(negedge aclk);
            @(negedge aclk);
            aresetn = 1'b1;
            repeat (12) begin
                @(negedge aclk);
                #1;
                if (done) dn++;
            end
            check(tag, "done_after_abort", dn, 0);
            return;
        end
        check(tag, "done_seen", finished, 1'b1);
        if (!finished) begin
            aresetn = 1'b0;
            @(negedge aclk);
            aresetn = 1'b1;
            return;
        end
        #1;
        check(tag, "done_one_cycle", done, 1'b0);
        check(tag, "ready_after_done", cmd_ready, 1'b1);
        check(tag, "status", got_st, v.exp_st);
        check(tag, "retries", got_rt, v.exp_rt);
        check(tag, "addr_handshakes", aw_n, v.exp_att);
        if (v.wr) begin
            check(tag, "w_beats", w_n, v.exp_att * (v.len + 1));
            check(tag, "w_data_last_bad", w_bad, 0);
        end else begin
            check(tag, "rd_beats", rd_n, v.len + 1);
            check(tag, "rd_data_last_bad", rd_bad, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        set_idle();
        // Reset state, with an upstream rvalid offered to prove pass-through is gated.
        rvalid = 1'b1; rd_ready = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        check("reset", "cmd_ready", cmd_ready, 1'b1);
        check("reset", "valids", {awvalid, wvalid, arvalid, rd_valid}, 4'b0000);
        check("reset", "readies", {wr_ready, bready, rready}, 3'b000);
        check("reset", "done_last", {done, wlast, rd_last}, 3'b000);
        set_idle();
        @(negedge aclk);
        aresetn = 1'b1;

        //           wr    addr     len base          script    lmask     emask     rnd   st     rt att lat
        vecs[0] = '{1'b1, 12'h010, 0,  32'h8000_0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 0, 1, 5};
        vecs[1] = '{1'b1, 12'h140, 15, 32'hA5A5_0000, 16'h000A, 16'h0000, 16'h0000, 1'b1, 2'b00, 2, 3, -1};
        vecs[2] = '{1'b1, 12'h200, 15, 32'h1234_5678, 16'h00AA, 16'h0000, 16'h0000, 1'b1, 2'b10, 3, 4, -1};
        vecs[3] = '{1'b1, 12'h300, 15, 32'hDEAD_BEEF, 16'h0003, 16'h0000, 16'h0000, 1'b1, 2'b10, 0, 1, -1};
        vecs[4] = '{1'b0, 12'h030, 0,  32'h0000_0010, 16'h0000, 16'h0001, 16'h0000, 1'b1, 2'b00, 0, 1, -1};
        vecs[5] = '{1'b0, 12'h400, 7,  32'hCAFE_0000, 16'h0000, 16'h0008, 16'h0020, 1'b1, 2'b11, 0, 1, -1};
        vecs[6] = '{1'b1, 12'h050, 3,  32'h0BAD_F00D, 16'h0001, 16'h0000, 16'h0000, 1'b0, 2'b00, 0, 1, 11};
        vecs[7] = '{1'b0, 12'h060, 3,  32'h7777_0000, 16'h0000, 16'h0008, 16'h0002, 1'b0, 2'b01, 0, 1, -1};
        for (int i = 0; i < 8; i++) run_cmd(vecs[i], -1, $sformatf("vec%0d", i));

        // Reset while beat 7 of a 16-beat write is on the W channel, then a clean command.
        r = '{1'b1, 12'h700, 15, 32'h5555_AAAA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 0, 1, 35};
        run_cmd(r, 7, "abort");
        r = '{1'b1, 12'h710, 3, 32'h0F0F_0F0F, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 0, 1, 11};
        run_cmd(r, -1, "post_abort");

        // Randomized commands against the transaction-level model.
        for (int t = 0; t < 30; t++) begin
            r.wr     = 1'($urandom_range(0, 1));
            r.addr   = 12'($urandom);
            r.len    = $urandom_range(0, 15);
            r.base   = $urandom;
            r.script = '0;
            for (int k = 0; k < 8; k++) r.script[2*k +: 2] = 2'($urandom_range(0, 3));
            r.lmask  = ($urandom_range(0, 1) == 1) ? (16'h1 << r.len) : 16'($urandom);
            r.emask  = ($urandom_range(0, 1) == 1) ? 16'h0 : 16'($urandom & $urandom);
            r.rnd    = 1'b1;
            r.exp_lat = -1;
            if (r.wr) begin
                model_write(r.script, r.exp_st, r.exp_rt, r.exp_att);
            end else begin
                r.exp_st  = model_read(r.len, r.lmask, r.emask);
                r.exp_rt  = 0;
                r.exp_att = 1;
            end
            run_cmd(r, -1, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
